// File: rtl/skewed_data_fetcher.sv
// Operand feeder for the systolic array: streams row vectors from a
// write-loadable buffer onto MATRIX_SIZE lanes, one vector every INTERVAL
// cycles, with optional diagonal skew (lane i delayed i cycles).
module skewed_data_fetcher #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int NUM_VECTORS = MATRIX_SIZE,
    parameter int INTERVAL    = 4,
    parameter int SKEW        = 1,
    localparam int DEPTH      = NUM_VECTORS * MATRIX_SIZE,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] data_out [MATRIX_SIZE-1:0],
    output logic [MATRIX_SIZE-1:0] valid_out,
    output logic                 busy,
    output logic                 done
);

    localparam int CW         = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int VW         = $clog2(NUM_VECTORS + 1);
    localparam int DRAIN_LEN  = (SKEW != 0) ? MATRIX_SIZE - 1 : 0;
    localparam int DRAIN_LAST = (DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0;
    localparam int DCW        = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e               state_q;
    logic [CW-1:0]        cnt_q;
    logic [VW-1:0]        vec_idx_q;
    logic [DCW-1:0]       drain_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 issue;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    assign busy = busy_q;
    assign done = done_q;

    // A vector leaves the buffer on the last count of each interval.
    assign issue = (state_q == StRun) && (cnt_q == CW'(INTERVAL - 1)) &&
                   (vec_idx_q != VW'(NUM_VECTORS));

    // Buffer write port: no reset, writes accepted in any state and during stalls.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Run sequencing; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            vec_idx_q <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (enable) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        vec_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StRun: begin
                    // The cycle after the last issue lets lane 0 present it
                    // before draining the skewed lanes.
                    if (vec_idx_q == VW'(NUM_VECTORS)) begin
                        drain_q <= '0;
                        if (DRAIN_LEN == 0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                        end
                    end else begin
                        cnt_q <= (cnt_q == CW'(INTERVAL - 1)) ? '0 : cnt_q + 1'b1;
                        if (issue) begin
                            vec_idx_q <= vec_idx_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_q == DCW'(DRAIN_LAST)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        // Stage 0 is the issue register shared by all lanes; skewed lanes add i more.
        localparam int STAGES = (SKEW != 0) ? i + 1 : 1;

        logic [DATA_SIZE-1:0] stage_data_q  [STAGES];
        logic                 stage_valid_q [STAGES];
        logic [DATA_SIZE-1:0] rd_data;

        assign rd_data = mem[AW'(int'(vec_idx_q) * MATRIX_SIZE + i)];

        // Lane shift register; idle cycles inject zero data with valid low.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s < STAGES; s++) begin
                    stage_data_q[s]  <= '0;
                    stage_valid_q[s] <= 1'b0;
                end
            end else if (enable) begin
                stage_data_q[0]  <= issue ? rd_data : '0;
                stage_valid_q[0] <= issue;
                for (int s = 1; s < STAGES; s++) begin
                    stage_data_q[s]  <= stage_data_q[s-1];
                    stage_valid_q[s] <= stage_valid_q[s-1];
                end
            end
        end

        assign data_out[i]  = stage_data_q[STAGES-1];
        assign valid_out[i] = stage_valid_q[STAGES-1];
    end

endmodule

// File: tb/tb_skewed_data_fetcher.sv
// Scoreboard bench: two instances (skewed and aligned) share stimulus; expected
// lane words and done pulses are queued per run and popped by a negedge monitor.
module tb_skewed_data_fetcher;

    localparam int IV = 4;

    typedef struct {
        int          t;
        logic [31:0] d;
    } item_t;

    logic        clk = 1'b0;
    logic        reset, enable, start, wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] dout0 [1:0];
    logic [31:0] dout1 [1:0];
    logic [1:0]  vout0, vout1;
    logic        busy0, busy1, done0, done1;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    bit    en_last = 1'b1;
    bit    mon_on = 1'b0;
    item_t lq [4][$];
    int    dq [2][$];
    logic [31:0] prev_d [4];
    logic        prev_v [4];

    skewed_data_fetcher #(.MATRIX_SIZE(2), .DATA_SIZE(32), .NUM_VECTORS(2),
                          .INTERVAL(IV), .SKEW(0)) u_dut0 (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .data_out(dout0), .valid_out(vout0),
        .busy(busy0), .done(done0)
    );

    skewed_data_fetcher #(.MATRIX_SIZE(2), .DATA_SIZE(32), .NUM_VECTORS(2),
                          .INTERVAL(IV), .SKEW(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .data_out(dout1), .valid_out(vout1),
        .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        en_last <= enable;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops expected words whenever a lane presents valid data.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 4; k++) begin
                logic        v;
                logic [31:0] d;
                item_t       it;
                v = (k < 2) ? vout0[k] : vout1[k-2];
                d = (k < 2) ? dout0[k] : dout1[k-2];
                if (!en_last) begin
                    chk($sformatf("hold_v%0d", k), 64'(v), 64'(prev_v[k]));
                    chk($sformatf("hold_d%0d", k), 64'(d), 64'(prev_d[k]));
                end else if (v === 1'b1) begin
                    if (lq[k].size() == 0) begin
                        chk($sformatf("unexpected_valid%0d", k), 64'(cyc), 64'(0));
                    end else begin
                        it = lq[k].pop_front();
                        chk($sformatf("lane_time%0d", k), 64'(cyc), 64'(it.t));
                        chk($sformatf("lane_data%0d", k), 64'(d), 64'(it.d));
                    end
                end else begin
                    chk($sformatf("idle_zero%0d", k), {31'b0, v, d}, 64'(0));
                end
                prev_v[k] = v;
                prev_d[k] = d;
            end
            for (int u = 0; u < 2; u++) begin
                logic dn;
                int   t;
                dn = (u == 0) ? done0 : done1;
                if (en_last && dn === 1'b1) begin
                    if (dq[u].size() == 0) begin
                        chk($sformatf("unexpected_done%0d", u), 64'(cyc), 64'(0));
                    end else begin
                        t = dq[u].pop_front();
                        chk($sformatf("done_time%0d", u), 64'(cyc), 64'(t));
                    end
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // One run. Offsets (relative to E0) of 0 disable the feature.
    task automatic run(input int stall_at, input int reset_at, input int restart_at,
                       input bit do_wr);
        logic [31:0] ew [4];
        int          e0, t, done_rel [2];
        ew[0] = 32'h11; ew[1] = 32'h22; ew[2] = 32'h33; ew[3] = 32'h44;
        if (do_wr) ew[2] = 32'h55;
        @(negedge clk);
        e0 = cyc + 1;
        for (int u = 0; u < 2; u++) begin
            for (int v = 0; v < 2; v++) begin
                for (int i = 0; i < 2; i++) begin
                    t = IV * (v + 1) + ((u == 1) ? i : 0);
                    if (stall_at > 0 && t >= stall_at) t += 3;
                    if (!(reset_at > 0 && t >= reset_at))
                        lq[u*2+i].push_back('{e0 + t, ew[v*2+i]});
                end
            end
            t = IV * 2 + ((u == 1) ? 1 : 0) + 1;
            if (stall_at > 0 && t >= stall_at) t += 3;
            done_rel[u] = t;
            if (!(reset_at > 0 && t >= reset_at)) dq[u].push_back(e0 + t);
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                chk("busy0", 64'(busy0), 64'((k - 1 < done_rel[0]) &&
                                            !(reset_at > 0 && k - 1 >= reset_at)));
                chk("busy1", 64'(busy1), 64'((k - 1 < done_rel[1]) &&
                                            !(reset_at > 0 && k - 1 >= reset_at)));
            end
            start   = (k == 0) || (restart_at > 0 && k == restart_at);
            enable  = !(stall_at > 0 && k >= stall_at && k < stall_at + 3);
            reset   = (reset_at > 0 && k == reset_at);
            wr_en   = do_wr && (k == 2 || k == 4);
            wr_addr = (k == 2) ? 2'd2 : 2'd0;
            wr_data = (k == 2) ? 32'h55 : 32'h99;
        end
        @(negedge clk);
        start = 1'b0; enable = 1'b1; reset = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("lane_left%0d", k), 64'(lq[k].size()), 64'(0));
        for (int u = 0; u < 2; u++) chk($sformatf("done_left%0d", u), 64'(dq[u].size()), 64'(0));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {busy1, busy0}, 64'(0));
        chk("rst_done", {done1, done0}, 64'(0));
        chk("rst_valid", {vout1, vout0}, 64'(0));
        chk("rst_data", {dout1[1], dout1[0]} | {dout0[1], dout0[0]}, 64'(0));
        reset = 1'b0;
        for (int a = 0; a < 4; a++) wr(2'(a), 32'h11 * (a + 1));
        mon_on = 1'b1;

        run(0, 0, 0, 1'b0);  // basic
        run(2, 0, 0, 1'b0);  // 3-cycle stall from E0+2
        run(0, 6, 0, 1'b0);  // reset mid-run
        run(0, 0, 0, 1'b0);  // replay after reset, buffer intact
        run(0, 0, 3, 1'b0);  // start while busy ignored
        run(0, 0, 0, 1'b1);  // late write seen, same-cycle write returns old
        wr(2'd0, 32'h11);
        wr(2'd2, 32'h33);
        run(0, 0, 0, 1'b0);  // buffer restored

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
